// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: multi-cycle MULT/MULTU/DIV/DIVU engine plus the HI/LO pair.
//
// Operands arrive from register-read beside the ALU.  mult/div run an
// iterative unsigned core on operand magnitudes; signs are restored when
// the result is written into HI/LO.  MTHI/MTLO write HI/LO in one cycle
// without raising busy or done.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, funct      request (sampled in IDLE only) and MIPS funct code
//   rs_content        operand A / dividend / MTxx source
//   rt_content        operand B / divisor
//   busy              operation in flight (pipeline stalls)
//   done              one-cycle pulse, hi/lo hold the new result
//   hi, lo            HI and LO registers
//
// Build option
//   MULDIV_FAST_MUL_EN  single-cycle 64-bit multiplier for mult/multu;
//                       divide is unaffected.  Results are identical.
module mips_cpu_muldiv #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // mul: {acc_hi, acc_lo} is the shifting product, acc_lo starts as multiplier
  // div: acc_hi is the partial remainder, acc_lo the dividend/quotient
  logic [WIDTH:0]   acc_hi_q, acc_hi_d, step_hi;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d, step_lo;
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] rs_q, rs_d;     // raw dividend, HI on divide-by-zero
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             op_div_q, op_div_d;
  logic             neg_q, neg_d;         // negate product / quotient
  logic             neg_rem_q, neg_rem_d; // negate remainder
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] res_hi, res_lo;

  // One clock worth of iteration steps.
  always_comb begin : step_c
    logic [WIDTH:0] r;
    logic [WIDTH:0] sum;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fprod;
    fprod = '0;
`endif
    r       = '0;
    sum     = '0;
    step_hi = acc_hi_q;
    step_lo = acc_lo_q;
    for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
      if (op_div_q) begin
        // restoring: shift in next dividend bit, subtract if it fits
        r = {step_hi[WIDTH-1:0], step_lo[WIDTH-1]};
        if (r >= {1'b0, opb_q}) begin
          step_hi = r - {1'b0, opb_q};
          step_lo = {step_lo[WIDTH-2:0], 1'b1};
        end else begin
          step_hi = r;
          step_lo = {step_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
`ifndef MULDIV_FAST_MUL_EN
        // shift-add: add multiplicand when multiplier LSB set, shift right
        sum     = step_lo[0] ? step_hi + {1'b0, opb_q} : step_hi;
        step_lo = {sum[0], step_lo[WIDTH-1:1]};
        step_hi = {1'b0, sum[WIDTH:1]};
`endif
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    if (!op_div_q) begin
      fprod   = {{WIDTH{1'b0}}, opb_q} * {{WIDTH{1'b0}}, acc_lo_q};
      step_hi = {1'b0, fprod[2*WIDTH-1:WIDTH]};
      step_lo = fprod[WIDTH-1:0];
    end
`endif
  end

  // Sign fix-up of the unsigned core result.
  always_comb begin : result_c
    logic [2*WIDTH-1:0] prod;
    prod = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    if (neg_q) prod = -prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_div_q) begin
      if (dz_q) begin
        res_lo = '1;
        res_hi = rs_q;
      end else begin
        res_lo = neg_q     ? -acc_lo_q             : acc_lo_q;
        res_hi = neg_rem_q ? -acc_hi_q[WIDTH-1:0]  : acc_hi_q[WIDTH-1:0];
      end
    end
  end

  // Next-state / datapath control.
  always_comb begin : fsm_c
    logic             sgn, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    rs_d      = rs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_div_d  = op_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    // even funct codes (mult, div) are the signed variants
    sgn   = ~funct[0];
    sa    = sgn & rs_content[WIDTH-1];
    sb    = sgn & rt_content[WIDTH-1];
    mag_a = sa ? -rs_content : rs_content;
    mag_b = sb ? -rt_content : rt_content;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (funct)
            F_MULT, F_MULTU: begin
              state_d   = S_MUL;
              op_div_d  = 1'b0;
              opb_d     = mag_a;
              acc_lo_d  = mag_b;
              acc_hi_d  = '0;
              neg_d     = sa ^ sb;
              neg_rem_d = 1'b0;
              dz_d      = 1'b0;
              rs_d      = rs_content;
`ifdef MULDIV_FAST_MUL_EN
              cnt_d     = CW'(STEPS_PER_CYCLE);
`else
              cnt_d     = CW'(WIDTH);
`endif
            end
            F_DIV, F_DIVU: begin
              state_d   = S_DIV;
              op_div_d  = 1'b1;
              opb_d     = mag_b;
              acc_lo_d  = mag_a;
              acc_hi_d  = '0;
              neg_d     = sa ^ sb;
              neg_rem_d = sa;
              dz_d      = (rt_content == '0);
              rs_d      = rs_content;
              cnt_d     = CW'(WIDTH);
            end
            F_MTHI: hi_d = rs_content;
            F_MTLO: lo_d = rs_content;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_FIN;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q - CW'(STEPS_PER_CYCLE);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      rs_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      rs_q      <= rs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_div_q  <= op_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign busy = (state_q == S_MUL) || (state_q == S_DIV);
  assign done = (state_q == S_FIN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
